// File: rtl/sudoku_io_pkg.sv
// sudoku_io_pkg: shared button indices, counts and repeat FSM state type
package sudoku_io_pkg;
   localparam int BTN_UP      = 0;
   localparam int BTN_DOWN    = 1;
   localparam int BTN_LEFT    = 2;
   localparam int BTN_RIGHT   = 3;
   localparam int BTN_START   = 4;
   localparam int BTN_A       = 5;
   localparam int BTN_B       = 6;
   localparam int NUM_BUTTONS = 7;
   localparam int NUM_DIRS    = 4;

   typedef enum logic [1:0] {
      RPT_IDLE,
      RPT_DELAY,
      RPT_REPEAT
   } rpt_state_e;
endpackage

// File: rtl/button_debouncer.sv
// button_debouncer: 2-flop synchronizer, debounce counter, stable level and press pulse
module button_debouncer #(
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_in,
   output logic stable,
   output logic press
);
   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [DW-1:0] DMAX = DW'(DEBOUNCE_CYCLES - 1);

   logic s1_q, s2_q, stable_q, stable_d, press_q, press_d;
   logic [DW-1:0] dcnt_q, dcnt_d;

   // accept a new level only after it persists DEBOUNCE_CYCLES cycles; any bounce back restarts the count
   always_comb begin
      stable_d = stable_q;
      dcnt_d   = '0;
      if (s2_q != stable_q) begin
         if (dcnt_q == DMAX) stable_d = s2_q;
         else dcnt_d = dcnt_q + 1'b1;
      end
      press_d = stable_d & ~stable_q;
   end

   // synchronizer and debounce state
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1_q     <= 1'b0;
         s2_q     <= 1'b0;
         stable_q <= 1'b0;
         dcnt_q   <= '0;
         press_q  <= 1'b0;
      end else begin
         s1_q     <= btn_in;
         s2_q     <= s1_q;
         stable_q <= stable_d;
         dcnt_q   <= dcnt_d;
         press_q  <= press_d;
      end
   end

   assign stable = stable_q;
   assign press  = press_q;
endmodule

// File: rtl/button_event_unit.sv
// button_event_unit: debounced press events and held levels, with auto-repeat on the directions
module button_event_unit
   import sudoku_io_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int REPEAT_DELAY    = 25000000,
   parameter int REPEAT_PERIOD   = 5000000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       up_button,
   input  logic       down_button,
   input  logic       left_button,
   input  logic       right_button,
   input  logic       start_button,
   input  logic       a_button,
   input  logic       b_button,
   input  logic       repeat_en,
   output logic       up_press,
   output logic       down_press,
   output logic       left_press,
   output logic       right_press,
   output logic       start_press,
   output logic       a_press,
   output logic       b_press,
   output logic [6:0] held
);
   localparam int RW = $clog2(REPEAT_DELAY + 1);
   localparam logic [RW-1:0] RD_MAX = RW'(REPEAT_DELAY - 1);
   localparam logic [RW-1:0] RP_MAX = RW'(REPEAT_PERIOD - 1);

   logic [NUM_BUTTONS-1:0] btn, stable, press, events;
   logic [NUM_DIRS-1:0]    rep;

   assign btn = {b_button, a_button, start_button, right_button, left_button, down_button, up_button};

   genvar b, d;
   generate
      for (b = 0; b < NUM_BUTTONS; b++) begin : g_btn
         button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
            .clk    (clk),
            .reset  (reset),
            .btn_in (btn[b]),
            .stable (stable[b]),
            .press  (press[b])
         );
      end
      for (d = 0; d < NUM_DIRS; d++) begin : g_rpt
         rpt_state_e      state_q;
         logic [RW-1:0]   rcnt_q;
         logic            pulse_q;
         // repeat FSM; rcnt counts cycles since the press pulse, so the IDLE->DELAY step already loads 1
         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               state_q <= RPT_IDLE;
               rcnt_q  <= '0;
               pulse_q <= 1'b0;
            end else begin
               pulse_q <= 1'b0;
               if (!repeat_en || !stable[d]) begin
                  state_q <= RPT_IDLE;
                  rcnt_q  <= '0;
               end else begin
                  case (state_q)
                     RPT_IDLE: begin
                        rcnt_q <= '0;
                        if (press[d]) begin
                           if (RD_MAX == '0) begin
                              pulse_q <= 1'b1;
                              state_q <= RPT_REPEAT;
                           end else begin
                              state_q <= RPT_DELAY;
                              rcnt_q  <= RW'(1);
                           end
                        end
                     end
                     RPT_DELAY: begin
                        if (rcnt_q == RD_MAX) begin
                           pulse_q <= 1'b1;
                           rcnt_q  <= '0;
                           state_q <= RPT_REPEAT;
                        end else rcnt_q <= rcnt_q + 1'b1;
                     end
                     RPT_REPEAT: begin
                        if (rcnt_q == RP_MAX) begin
                           pulse_q <= 1'b1;
                           rcnt_q  <= '0;
                        end else rcnt_q <= rcnt_q + 1'b1;
                     end
                     default: begin
                        state_q <= RPT_IDLE;
                        rcnt_q  <= '0;
                     end
                  endcase
               end
            end
         end
         assign rep[d] = pulse_q;
      end
   endgenerate

   assign events      = press | {{(NUM_BUTTONS-NUM_DIRS){1'b0}}, rep};
   assign up_press    = events[BTN_UP];
   assign down_press  = events[BTN_DOWN];
   assign left_press  = events[BTN_LEFT];
   assign right_press = events[BTN_RIGHT];
   assign start_press = events[BTN_START];
   assign a_press     = events[BTN_A];
   assign b_press     = events[BTN_B];
   assign held        = stable;
endmodule

// File: doc/button_event_unit.md
# button_event_unit

Converts the seven normalized, active-high button levels into clean game events: per-button synchronization and debounce, a one-cycle press pulse per debounced press, and auto-repeat pulses on the four direction buttons while held. Sits between the button polarity-normalization stage and the game/cursor FSM. The consumer only ever sees single-cycle, glitch-free press events and stable held levels.

## Interface
- `DEBOUNCE_CYCLES`, default 50000: consecutive cycles a new level must persist before it is accepted. Must be ≥1.
- `REPEAT_DELAY`, default 25000000: cycles a direction is held after its press pulse before the first repeat pulse. Must be ≥ `REPEAT_PERIOD`.
- `REPEAT_PERIOD`, default 5000000: cycles between subsequent repeat pulses. Must be ≥1.
- `clk`  in  1  system clock; all state on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `up_button`, `down_button`, `left_button`, `right_button`, `start_button`, `a_button`, `b_button`  in  1 each  normalized levels, 1 = pressed. Asynchronous to `clk`.
- `repeat_en`  in  1  enables auto-repeat on the directions. Sampled every cycle.
- `up_press`, `down_press`, `left_press`, `right_press`, `start_press`, `a_press`, `b_press`  out  1 each  one-cycle event pulses.
- `held`  out  7  debounced levels. Bit order: [0] up, [1] down, [2] left, [3] right, [4] start, [5] a, [6] b.

## Operation
- Seven independent channels. Each has:
  - a 2-flop synchronizer (`s1`, `s2`);
  - a debounce counter `dcnt`, width `$clog2(DEBOUNCE_CYCLES+1)`;
  - a stable level `stable`, which drives the channel's `held` bit.
- Debounce:
  - If `s2 == stable`, then `dcnt <= 0`.
  - Otherwise `dcnt` increments.
  - When `s2 != stable` and `dcnt == DEBOUNCE_CYCLES-1`, then `stable <= s2` and `dcnt <= 0`.
  - Any bounce back to `stable` restarts the count.
- Press pulse: a registered `press` is set for one cycle on the same edge where `stable` goes 0→1. There is no pulse on release.
- Auto-repeat, direction channels only, each with a repeat counter `rcnt` wide enough for `REPEAT_DELAY`. FSM states:
  - IDLE: `rcnt = 0`. Go to DELAY on the press edge.
  - DELAY: `rcnt` counts. When `rcnt == REPEAT_DELAY-1`, emit a pulse, clear `rcnt`, go to REPEAT.
  - REPEAT: when `rcnt == REPEAT_PERIOD-1`, emit a pulse and clear `rcnt`.
  - From any state: `stable == 0` or `repeat_en == 0` → IDLE with `rcnt` cleared.
- Direction press output = debounce pulse OR repeat pulse. These are mutually exclusive by construction.
- start, a and b never repeat.
- Simultaneous events: channels are fully independent. Any combination of `*_press` may be high in the same cycle. No priority or suppression.
- Reset (async assert, any time): `s1`, `s2`, `stable`, `dcnt`, `rcnt` cleared; FSMs to IDLE.
  - A button held through reset release therefore produces one normal press after debounce.
- `repeat_en` deasserted mid-hold: repeats stop immediately. Re-asserting it while still held does not restart repeats until the next release and press.

## Timing
- Reset values: all `*_press` = 0, `held` = 7'b0.
- Press latency, raw level steady from sampling edge E0 (value captured into `s1`):
  - `stable` and `press` update at edge E0 + 1 + `DEBOUNCE_CYCLES`.
  - `held` rises in the same cycle that `press` is high.
- Release latency: `held` falls at E0 + 1 + `DEBOUNCE_CYCLES` after the release is sampled.
- First repeat pulse: `REPEAT_DELAY` cycles after the press pulse cycle.
- Subsequent repeat pulses: spaced exactly `REPEAT_PERIOD` cycles apart.
- Every pulse is exactly one cycle wide. Outputs are registered, with no combinational path from inputs.

## Structure
- Shared package `sudoku_io_pkg`:
  - button index constants `BTN_UP`=0 … `BTN_B`=6;
  - `NUM_BUTTONS`=7;
  - `NUM_DIRS`=4.
- One sub-module, `button_debouncer`, containing synchronizer, debounce counter, `stable` and press pulse. It is instantiated seven times.
- The repeat FSM lives in the top level, in a generate loop over the four directions.

## Test plan
Bench parameters: `DEBOUNCE_CYCLES`=4, `REPEAT_DELAY`=20, `REPEAT_PERIOD`=8.

- **Clean press:** `a_button` 0→1 held 40 cycles → `a_press` high exactly one cycle at E0+5, `held[5]` high from that cycle. Release → `held[5]` low 5 cycles after release is sampled, with no pulse.
- **Bounce:** `up_button` toggles every 2 cycles for 20 cycles, then stays 1 → no pulse during bouncing; exactly one `up_press` 5 cycles after the level settles.
- **Auto-repeat:** `right_button` held 60 cycles with `repeat_en`=1 → pulses at press cycle P, P+20, P+28, P+36, …. With `repeat_en`=0, only the P pulse.
- **Simultaneous:** `start_button`, `b_button` and `down_button` rise on the same edge → all three pulses in the same cycle; `held` = 7'b1010010.
- **Reset mid-operation:** `left_button` held; assert `reset` during the DELAY state → all outputs 0 immediately. Release reset with the button still held → one `left_press` after 5 cycles, then repeat at +20.
- **No repeat on action buttons:** `start_button` held 100 cycles → exactly one `start_press`.
